// File: rtl/vecmac_accum.sv
// vecmac_accum: sums cfg_len partial dot products per group into a one-entry result slot.
// Define VECMAC_ACC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module vecmac_accum #(
   parameter int IN_W  = 18,
   parameter int LEN_W = 8,
   parameter int ACC_W = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] cfg_len,
   output logic             busy,
   input  logic             in_valid,
   input  logic [IN_W-1:0]  in_sum,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_ovf,
   output logic             err_drop
);
   typedef enum logic {IDLE, ACC} state_t;
   state_t state, state_nx;
   logic [LEN_W-1:0] cnt;
   logic [ACC_W-1:0] acc, acc_nx;
   logic [ACC_W:0] sum;
   logic ovf, ovf_nx, last, accept;
   assign busy = state == ACC;
   assign last = cnt == LEN_W'(1);
   // the final beat may only land if the slot is empty or drains on the same edge
   assign in_ready = busy && (!last || !out_valid || out_ready);
   assign accept = in_valid && in_ready;
   assign sum = {1'b0, acc} + (ACC_W+1)'(in_sum);
   assign ovf_nx = ovf | sum[ACC_W];
`ifdef VECMAC_ACC_SAT_EN
   assign acc_nx = ovf_nx ? '1 : sum[ACC_W-1:0];
`else
   assign acc_nx = sum[ACC_W-1:0];
`endif
   always_comb begin
      state_nx = state;
      if (start) state_nx = cfg_len != '0 ? ACC : IDLE;
      else if (accept && last) state_nx = IDLE;
   end
   always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt       <= '0;
         acc       <= '0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_ovf   <= 1'b0;
         err_drop  <= 1'b0;
      end else begin
         err_drop <= err_drop | (in_valid & ~in_ready);
         if (start) begin
            cnt <= cfg_len;
            acc <= '0;
            ovf <= 1'b0;
         end else if (accept) begin
            cnt <= cnt - LEN_W'(1);
            acc <= acc_nx;
            ovf <= ovf_nx;
         end
         if (accept && last && !start) begin
            out_valid <= 1'b1;
            out_acc   <= acc_nx;
            out_ovf   <= ovf_nx;
         end else if (out_ready) out_valid <= 1'b0;
      end
   end
endmodule
